// File: rtl/hazard_stall_controller.sv
// Pipeline stall controller: per-class stall windows, halt/resume,
// external stall request and a registered NOP-select for program memory.
module hazard_stall_controller #(
  parameter int unsigned INS_W     = 20,
  parameter int unsigned OPC_W     = 5,
  parameter int unsigned OPC_LSB   = 15,
  parameter int unsigned CNT_W     = 4,
  parameter logic [OPC_W-1:0] OPC_LD  = 5'b10001,
  parameter logic [OPC_W-1:0] OPC_JMP = 5'b10100,
  parameter logic [OPC_W-1:0] OPC_BR  = 5'b10101,
  parameter logic [OPC_W-1:0] OPC_HLT = 5'b11110,
  parameter int unsigned LD_STALL  = 1,
  parameter int unsigned JMP_STALL = 2,
  parameter int unsigned BR_STALL  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [INS_W-1:0] ins_pm,
  input  logic             ext_stall,
  input  logic             resume,
  output logic             stall,
  output logic             stall_pm,
  output logic             halted
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    CNT  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] K_LD  = CNT_W'(LD_STALL);
  localparam logic [CNT_W-1:0] K_JMP = CNT_W'(JMP_STALL);
  localparam logic [CNT_W-1:0] K_BR  = CNT_W'(BR_STALL);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [OPC_W-1:0] opc;
  logic             hit_hlt;
  logic [CNT_W-1:0] k;
  logic             hit;

  assign opc = ins_pm[OPC_LSB+OPC_W-1:OPC_LSB];

  // Opcode decode; a rule with K=0 yields no stall.
  always_comb begin
    hit_hlt = 1'b0;
    k       = '0;
    priority case (1'b1)
      (opc == OPC_HLT): hit_hlt = 1'b1;
      (opc == OPC_JMP): k = K_JMP;
      (opc == OPC_BR):  k = K_BR;
      (opc == OPC_LD):  k = K_LD;
      default:          k = '0;
    endcase
  end

  assign hit = hit_hlt | (k != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      cnt      <= '0;
      stall_pm <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      stall_pm <= stall;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      RUN: begin
        if (!ext_stall) begin
          if (hit_hlt) begin
            state_nxt = HALT;
          end else if (k > ONE) begin
            state_nxt = CNT;
            cnt_nxt   = k - ONE;
          end
        end
      end
      CNT: begin
        if (!ext_stall) begin
          if (cnt == ONE) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt - ONE;
          end
        end
      end
      HALT: begin
        if (resume) state_nxt = RUN;
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    stall  = 1'b0;
    halted = (state == HALT);
    if (!reset) begin
      stall = (state != RUN) | ext_stall | hit;
    end
  end

endmodule
